mrd_tlp_requester: RTL and testbench

//  Builds upstream PCIe Memory Read request TLPs for a DMA engine and drives them on the 64-bit
//  TRN TX interface. Waits for the one-cycle tx_turn grant from the endpoint arbiter, holds
//  tx_driven while it owns TX, and pulses consumed_tag so the arbiter advances its tag counter.

---
 rtl/mrd_tlp_requester.sv | 177 +++++++++++++++++
 tb/tb_mrd_tlp_requester.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mrd_tlp_requester.sv
// ============================================================================
// Module   : mrd_tlp_requester
// Brief    : Builds PCIe MRd request TLPs for a DMA engine and drives them on
//            the 64-bit TRN TX interface, limiting outstanding reads.
//            Optional: MRD_64BIT_ADDR_EN enables 4DW headers for addresses
//            above 4 GiB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mrd_tlp_requester #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 8
) (
  input  logic             trn_clk,
  input  logic             reset,
  input  logic [15:0]      cfg_completer_id,
  input  logic [7:0]       tag,
  output logic             consumed_tag,
  input  logic             tx_turn,
  output logic             tx_driven,
  input  logic             req_valid,
  input  logic [63:0]      req_addr,
  input  logic [9:0]       req_len_dw,
  output logic             req_ack,
  input  logic             cpl_done,
  output logic [CNT_W-1:0] outstanding,
  output logic [63:0]      trn_td,
  output logic [7:0]       trn_trem_n,
  output logic             trn_tsof_n,
  output logic             trn_teof_n,
  output logic             trn_tsrc_rdy_n,
  input  logic             trn_tdst_rdy_n,
  input  logic             trn_tbuf_av
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_HDR1 = 2'd1;
  localparam logic [1:0] C_HDR2 = 2'd2;

  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [7:0]       r_tag;
  logic [29:0]      r_addr_lo;
  logic [9:0]       r_len;
  logic [CNT_W-1:0] r_outstanding;
  logic             r_consumed_tag;
  logic             r_req_ack;

  logic             w_start;
  logic             w_beat0_acc;
  logic             w_beat1_acc;
  logic             w_dec;
  logic [1:0]       w_fmt;
  logic [31:0]      w_dw0;
  logic [31:0]      w_dw1;
  logic [63:0]      w_beat1;
  logic [7:0]       w_trem1;
  logic             w_unused_addr;

  assign w_start     = (r_state == C_IDLE) && tx_turn && req_valid &&
                       (r_outstanding < C_MAX) && trn_tbuf_av;
  assign w_beat0_acc = (r_state == C_HDR1) && !trn_tdst_rdy_n;
  assign w_beat1_acc = (r_state == C_HDR2) && !trn_tdst_rdy_n;
  // A completion arriving with nothing in flight is stray and must not wrap.
  assign w_dec       = cpl_done && (r_outstanding != '0);

`ifdef MRD_64BIT_ADDR_EN
  logic        r_is4dw;
  logic [31:0] r_addr_hi;

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_is4dw   <= 1'b0;
      r_addr_hi <= '0;
    end else if (w_start) begin
      r_is4dw   <= (req_addr[63:32] != 32'd0);
      r_addr_hi <= req_addr[63:32];
    end
  end

  assign w_fmt         = r_is4dw ? 2'b01 : 2'b00;
  assign w_beat1       = r_is4dw ? {r_addr_hi, r_addr_lo, 2'b00}
                                 : {r_addr_lo, 2'b00, 32'd0};
  assign w_trem1       = r_is4dw ? 8'h00 : 8'h0F;
  assign w_unused_addr = &{1'b0, req_addr[1:0]};
`else
  assign w_fmt         = 2'b00;
  assign w_beat1       = {r_addr_lo, 2'b00, 32'd0};
  assign w_trem1       = 8'h0F;
  assign w_unused_addr = &{1'b0, req_addr[63:32], req_addr[1:0]};
`endif

  assign w_dw0 = {1'b0, w_fmt, 5'b00000, 1'b0, 3'b000, 4'b0000,
                  1'b0, 1'b0, 2'b00, 2'b00, r_len};
  assign w_dw1 = {cfg_completer_id, r_tag,
                  (r_len == 10'd1) ? 4'h0 : 4'hF, 4'hF};

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_IDLE:  if (w_start)     w_next_state = C_HDR1;
      C_HDR1:  if (w_beat0_acc) w_next_state = C_HDR2;
      C_HDR2:  if (w_beat1_acc) w_next_state = C_IDLE;
      default:                  w_next_state = C_IDLE;
    endcase
  end

  // TX outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    tx_driven      = 1'b0;
    trn_td         = 64'd0;
    trn_trem_n     = 8'hFF;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    case (r_state)
      C_HDR1: begin
        tx_driven      = 1'b1;
        trn_td         = {w_dw0, w_dw1};
        trn_trem_n     = 8'h00;
        trn_tsof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
      end
      C_HDR2: begin
        tx_driven      = 1'b1;
        trn_td         = w_beat1;
        trn_trem_n     = w_trem1;
        trn_teof_n     = 1'b0;
        trn_tsrc_rdy_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_tag          <= '0;
      r_addr_lo      <= '0;
      r_len          <= '0;
      r_outstanding  <= '0;
      r_consumed_tag <= 1'b0;
      r_req_ack      <= 1'b0;
    end else begin
      if (w_start) begin
        r_tag     <= tag;
        r_addr_lo <= req_addr[31:2];
        r_len     <= req_len_dw;
      end
      r_consumed_tag <= w_beat0_acc;
      r_req_ack      <= w_beat1_acc;
      case ({w_beat0_acc, w_dec})
        2'b10:   r_outstanding <= r_outstanding + C_ONE;
        2'b01:   r_outstanding <= r_outstanding - C_ONE;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign consumed_tag = r_consumed_tag;
  assign req_ack      = r_req_ack;
  assign outstanding  = r_outstanding;

endmodule

`default_nettype wire

// File: tb/tb_mrd_tlp_requester.sv
// ============================================================================
// Module   : tb_mrd_tlp_requester
// Brief    : Scoreboard bench for mrd_tlp_requester (directed TLP vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mrd_tlp_requester;

  logic        trn_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [15:0] cfg_completer_id = 16'hBEEF;
  logic [7:0]  tag = 8'h00;
  logic        consumed_tag;
  logic        tx_turn = 1'b0;
  logic        tx_driven;
  logic        req_valid = 1'b0;
  logic [63:0] req_addr = 64'd0;
  logic [9:0]  req_len_dw = 10'd0;
  logic        req_ack;
  logic        cpl_done = 1'b0;
  logic [7:0]  outstanding;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n = 1'b0;
  logic        trn_tbuf_av = 1'b1;

  mrd_tlp_requester #(.MAX_OUTSTANDING(4), .CNT_W(8)) dut (
    .trn_clk          (trn_clk),
    .reset            (reset),
    .cfg_completer_id (cfg_completer_id),
    .tag              (tag),
    .consumed_tag     (consumed_tag),
    .tx_turn          (tx_turn),
    .tx_driven        (tx_driven),
    .req_valid        (req_valid),
    .req_addr         (req_addr),
    .req_len_dw       (req_len_dw),
    .req_ack          (req_ack),
    .cpl_done         (cpl_done),
    .outstanding      (outstanding),
    .trn_td           (trn_td),
    .trn_trem_n       (trn_trem_n),
    .trn_tsof_n       (trn_tsof_n),
    .trn_teof_n       (trn_teof_n),
    .trn_tsrc_rdy_n   (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n   (trn_tdst_rdy_n),
    .trn_tbuf_av      (trn_tbuf_av)
  );

  always #5 trn_clk = ~trn_clk;

  typedef struct packed {
    logic [63:0] td;
    logic        sof_n;
    logic        eof_n;
    logic [7:0]  trem_n;
  } beat_t;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_ct     = 0;
  int n_ack    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat is popped and checked against the scoreboard.
  always @(negedge trn_clk) begin
    if (!reset && !trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", trn_td, 64'd0);
        chk("unexpected_beat_valid", 64'd1, 64'd0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_td", trn_td, e.td);
        chk("beat_sof_n", {63'd0, trn_tsof_n}, {63'd0, e.sof_n});
        chk("beat_eof_n", {63'd0, trn_teof_n}, {63'd0, e.eof_n});
        chk("beat_trem_n", {56'd0, trn_trem_n}, {56'd0, e.trem_n});
      end
    end
    if (consumed_tag) n_ct++;
    if (req_ack) n_ack++;
  end

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic pulse_cpl();
    tick(); cpl_done = 1'b1;
    tick(); cpl_done = 1'b0;
  endtask

  task automatic issue(input logic [63:0] addr, input logic [9:0] len, input logic [7:0] t,
                       input logic [63:0] b0, input logic [63:0] b1, input logic [7:0] trem1,
                       input int hold1, input int hold2, input bit coinc, input bit abort_tlp,
                       input logic [7:0] exp_out);
    int ct0, ack0;
    bit got;
    ct0 = n_ct; ack0 = n_ack; got = 0;
    exp_q.push_back('{td: b0, sof_n: 1'b0, eof_n: 1'b1, trem_n: 8'h00});
    if (!abort_tlp) exp_q.push_back('{td: b1, sof_n: 1'b1, eof_n: 1'b0, trem_n: trem1});
    tick();
    req_valid = 1'b1; req_addr = addr; req_len_dw = len; tag = t;
    tx_turn = 1'b1; trn_tdst_rdy_n = (hold1 > 0);
    tick();
    tx_turn = 1'b0; cpl_done = coinc;
    req_addr = ~addr; req_len_dw = ~len; tag = ~t;
    for (int i = 0; i < hold1; i++) begin
      @(negedge trn_clk);
      chk("hold1_tx_driven", {63'd0, tx_driven}, 64'd1);
      chk("hold1_td", trn_td, b0);
      tick();
    end
    trn_tdst_rdy_n = 1'b0;
    tick();
    cpl_done = 1'b0;
    trn_tdst_rdy_n = (hold2 > 0) || abort_tlp;
    for (int i = 0; i < hold2; i++) begin
      @(negedge trn_clk);
      chk("hold2_tx_driven", {63'd0, tx_driven}, 64'd1);
      chk("hold2_td", trn_td, b1);
      tick();
    end
    if (abort_tlp) begin
      @(negedge trn_clk);
      chk("abort_in_hdr2", {63'd0, trn_teof_n}, 64'd0);
      #2 reset = 1'b1;
      #1;
      chk("abort_tx_driven", {63'd0, tx_driven}, 64'd0);
      chk("abort_src_rdy_n", {63'd0, trn_tsrc_rdy_n}, 64'd1);
      chk("abort_outstanding", {56'd0, outstanding}, 64'd0);
      chk("abort_td", trn_td, 64'd0);
      tick();
      reset = 1'b0; trn_tdst_rdy_n = 1'b0; req_valid = 1'b0;
      tick();
      return;
    end
    trn_tdst_rdy_n = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge trn_clk);
      if (req_ack) got = 1;
    end
    chk("req_ack_seen", {63'd0, got}, 64'd1);
    req_valid = 1'b0;
    tick();
    chk("consumed_tag_once", 64'(n_ct - ct0), 64'd1);
    chk("req_ack_once", 64'(n_ack - ack0), 64'd1);
    chk("outstanding", {56'd0, outstanding}, {56'd0, exp_out});
  endtask

  task automatic grant_ignored(input string name);
    tick();
    req_valid = 1'b1; tx_turn = 1'b1;
    tick();
    tx_turn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge trn_clk);
      chk(name, {62'd0, tx_driven, ~trn_tsrc_rdy_n}, 64'd0);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_tx_driven", {63'd0, tx_driven}, 64'd0);
    chk("rst_src_rdy_n", {63'd0, trn_tsrc_rdy_n}, 64'd1);
    chk("rst_sof_eof", {62'd0, trn_tsof_n, trn_teof_n}, 64'd3);
    chk("rst_trem_n", {56'd0, trn_trem_n}, 64'hFF);
    chk("rst_td", trn_td, 64'd0);
    chk("rst_outstanding", {56'd0, outstanding}, 64'd0);
    chk("rst_pulses", {62'd0, consumed_tag, req_ack}, 64'd0);
    tick();
    reset = 1'b0;

    // Grant with no pending request.
    tick(); tx_turn = 1'b1;
    tick(); tx_turn = 1'b0;
    @(negedge trn_clk);
    chk("grant_no_req", {63'd0, tx_driven}, 64'd0);

    issue(64'h0000_0000_1234_5678, 10'd16, 8'h05,
          64'h00000010_BEEF05FF, 64'h12345678_00000000, 8'h0F, 0, 0, 0, 0, 8'd1);
`ifdef MRD_64BIT_ADDR_EN
    issue(64'h0000_0001_0000_0040, 10'd1, 8'h06,
          64'h20000001_BEEF060F, 64'h00000001_00000040, 8'h00, 0, 0, 0, 0, 8'd2);
`else
    issue(64'h0000_0001_0000_0040, 10'd1, 8'h06,
          64'h00000001_BEEF060F, 64'h00000040_00000000, 8'h0F, 0, 0, 0, 0, 8'd2);
`endif
    // cpl_done on the same edge as beat0 accept leaves the count unchanged.
    issue(64'h0000_0000_0000_1000, 10'd2, 8'h07,
          64'h00000002_BEEF07FF, 64'h00001000_00000000, 8'h0F, 0, 0, 1, 0, 8'd2);
    issue(64'h0000_0000_ABCD_EF03, 10'd0, 8'h22,
          64'h00000000_BEEF22FF, 64'hABCDEF00_00000000, 8'h0F, 0, 0, 0, 0, 8'd3);
    issue(64'h0000_0000_0000_2000, 10'd4, 8'h30,
          64'h00000004_BEEF30FF, 64'h00002000_00000000, 8'h0F, 0, 0, 0, 0, 8'd4);

    grant_ignored("grant_at_max");
    pulse_cpl();
    @(negedge trn_clk);
    chk("after_cpl", {56'd0, outstanding}, 64'd3);
    issue(64'h0000_0000_0000_3000, 10'd8, 8'h31,
          64'h00000008_BEEF31FF, 64'h00003000_00000000, 8'h0F, 0, 0, 0, 0, 8'd4);

    pulse_cpl();
    issue(64'h0000_0000_FFFF_FFFC, 10'h3FF, 8'h40,
          64'h000003FF_BEEF40FF, 64'hFFFFFFFC_00000000, 8'h0F, 5, 5, 0, 0, 8'd4);

    for (int i = 0; i < 4; i++) pulse_cpl();
    @(negedge trn_clk);
    chk("drained", {56'd0, outstanding}, 64'd0);
    pulse_cpl();
    @(negedge trn_clk);
    chk("cpl_at_zero", {56'd0, outstanding}, 64'd0);

    trn_tbuf_av = 1'b0;
    grant_ignored("grant_no_buf");
    trn_tbuf_av = 1'b1;

    issue(64'h0000_0000_0000_4000, 10'd3, 8'h50,
          64'h00000003_BEEF50FF, 64'h0, 8'h0F, 0, 0, 0, 1, 8'd0);

    tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
